// File: rtl/simon_input_conditioner_if.sv
// -----------------------------------------------------------------------------
// simon_input_conditioner_if
// Bundles the raw board inputs and the conditioned outputs of
// simon_input_conditioner.
//   master : the board/stimulus side. Drives the raw pins and observes the
//            conditioned signals.
//   slave  : the conditioner. Reads the raw pins and drives the conditioned
//            signals.
// Signals:
//   btn_raw, level_raw, pattern_raw[3:0]    raw asynchronous inputs
//   step, btn_db                            step pulse and debounced button
//   level_db, pattern_db[3:0]               debounced level/pattern values
//   level_snap, pattern_snap[3:0]           values captured at each step
// -----------------------------------------------------------------------------
interface simon_input_conditioner_if;
  logic       btn_raw;
  logic       level_raw;
  logic [3:0] pattern_raw;
  logic       step;
  logic       btn_db;
  logic       level_db;
  logic [3:0] pattern_db;
  logic       level_snap;
  logic [3:0] pattern_snap;

  modport master (
    output btn_raw, level_raw, pattern_raw,
    input  step, btn_db, level_db, pattern_db, level_snap, pattern_snap
  );

  modport slave (
    input  btn_raw, level_raw, pattern_raw,
    output step, btn_db, level_db, pattern_db, level_snap, pattern_snap
  );
endinterface

// File: rtl/simon_input_conditioner.sv
// -----------------------------------------------------------------------------
// simon_input_conditioner
// Front end for the Simon top level. It synchronises the raw push-button,
// level switch and pattern switches. It debounces them and produces:
//   - a one-clk step pulse for each debounced button press.
//   - debounced level/pattern values.
//   - level/pattern snapshots taken on the edge that raises step.
// Ports:
//   clk  : system clock
//   rst  : asynchronous, active-low reset. Clears all state while low.
//   bus  : simon_input_conditioner_if.slave, which carries the raw inputs
//          and the conditioned outputs.
// Parameters:
//   SYNC_STAGES     : synchroniser depth (2..4)
//   DEBOUNCE_CYCLES : number of stable cycles needed before a debounced
//                     value changes
//   CNT_W           : debounce counter width
// Build option:
//   SIMON_STEP_ON_RELEASE_EN : when defined, step fires on the debounced
//                              release instead of the debounced press.
//                              btn_db is unaffected.
// -----------------------------------------------------------------------------
module simon_input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input logic                      clk,
  input logic                      rst,
  simon_input_conditioner_if.slave bus
);

  localparam logic [CNT_W-1:0] DB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef SIMON_STEP_ON_RELEASE_EN
  localparam bit STEP_ON_RELEASE = 1'b1;
`else
  localparam bit STEP_ON_RELEASE = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  // Synchroniser chain. Bit 5 is the button, bit 4 is the level switch and
  // bits [3:0] are the pattern switches.
  logic [SYNC_STAGES-1:0][5:0] sync_q, sync_d;
  logic                        btn_s;
  logic [4:0]                  grp_s;

  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] btn_cnt_q, btn_cnt_d;
  logic             step_q, step_d;

  logic [4:0]       grp_prev_q, grp_prev_d;
  logic [CNT_W-1:0] grp_cnt_q, grp_cnt_d;
  logic [4:0]       grp_db_q, grp_db_d;
  logic [4:0]       snap_q, snap_d;

  always_comb begin
    sync_d    = '0;
    sync_d[0] = {bus.btn_raw, bus.level_raw, bus.pattern_raw};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign btn_s = sync_q[SYNC_STAGES-1][5];
  assign grp_s = sync_q[SYNC_STAGES-1][4:0];

  // Button FSM. The registered step pulse is high in the cycle after the
  // qualifying edge. That cycle is the first one in which btn_db shows the
  // new level.
  always_comb begin
    state_d   = state_q;
    btn_cnt_d = '0;
    step_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d   = PRESS_WAIT;
          btn_cnt_d = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_d = IDLE;
        end else if (btn_cnt_q == DB_LIMIT) begin
          state_d = HELD;
          step_d  = !STEP_ON_RELEASE;
        end else begin
          btn_cnt_d = btn_cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_d   = RELEASE_WAIT;
          btn_cnt_d = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_d = HELD;
        end else if (btn_cnt_q == DB_LIMIT) begin
          state_d = IDLE;
          step_d  = STEP_ON_RELEASE;
        end else begin
          btn_cnt_d = btn_cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Group debounce for level and pattern. Any change restarts the count.
  // The counter saturates at the limit. The debounced value loads on the
  // edge where the counter reaches the limit, so it appears
  // SYNC_STAGES + DEBOUNCE_CYCLES edges after the raw change.
  always_comb begin
    grp_prev_d = grp_s;
    grp_cnt_d  = grp_cnt_q;
    grp_db_d   = grp_db_q;
    if (grp_s != grp_prev_q) begin
      grp_cnt_d = '0;
    end else begin
      if (grp_cnt_q != DB_LIMIT) begin
        grp_cnt_d = grp_cnt_q + CNT_ONE;
      end
      if (grp_cnt_d == DB_LIMIT) begin
        grp_db_d = grp_s;
      end
    end
    // The snapshot reads the registered debounced value. If a group update
    // lands on the same edge as step, the snapshot keeps the old value.
    snap_d = step_d ? grp_db_q : snap_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q     <= '0;
      state_q    <= IDLE;
      btn_cnt_q  <= '0;
      step_q     <= 1'b0;
      grp_prev_q <= '0;
      grp_cnt_q  <= '0;
      grp_db_q   <= '0;
      snap_q     <= '0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      btn_cnt_q  <= btn_cnt_d;
      step_q     <= step_d;
      grp_prev_q <= grp_prev_d;
      grp_cnt_q  <= grp_cnt_d;
      grp_db_q   <= grp_db_d;
      snap_q     <= snap_d;
    end
  end

  assign bus.step         = step_q;
  assign bus.btn_db       = (state_q == HELD) || (state_q == RELEASE_WAIT);
  assign bus.level_db     = grp_db_q[4];
  assign bus.pattern_db   = grp_db_q[3:0];
  assign bus.level_snap   = snap_q[4];
  assign bus.pattern_snap = snap_q[3:0];

endmodule

// File: tb/tb_simon_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_simon_input_conditioner
// Directed, table-driven bench for simon_input_conditioner built with
// SYNC_STAGES=2 and DEBOUNCE_CYCLES=4. Inputs are driven 1 time unit after a
// rising edge. Outputs are sampled 1 time unit after the edge. Row k of a
// sequence is the state just after the k-th edge, counting from the edge that
// first captures the new input (row 0).
// -----------------------------------------------------------------------------
module tb_simon_input_conditioner;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  simon_input_conditioner_if bus_if ();

  simon_input_conditioner #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

`ifdef SIMON_STEP_ON_RELEASE_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif

  typedef struct {
    logic       btn;
    logic       exp_step;
    logic       exp_btn_db;
    logic       exp_lvl_snap;
    logic [3:0] exp_pat_snap;
  } vec_t;

  vec_t tbl [28];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".step"},         8'(bus_if.step),         8'h0);
    check({tag, ".btn_db"},       8'(bus_if.btn_db),       8'h0);
    check({tag, ".level_db"},     8'(bus_if.level_db),     8'h0);
    check({tag, ".pattern_db"},   8'(bus_if.pattern_db),   8'h0);
    check({tag, ".level_snap"},   8'(bus_if.level_snap),   8'h0);
    check({tag, ".pattern_snap"}, 8'(bus_if.pattern_snap), 8'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int snap_row;
    int steps;
    int step_row;
    logic seen_step;
    logic seen_db;
    logic pat_moved;

    // ---- reset ----
    rst = 1'b0;
    bus_if.btn_raw     = 1'b0;
    bus_if.level_raw   = 1'b0;
    bus_if.pattern_raw = 4'b0000;
    repeat (3) tick();
    check_all_zero("reset_low");
    rst = 1'b1;
    tick();
    check_all_zero("reset_release");
    $display("reset sequence done");

    // ---- level/pattern settle before the press ----
    bus_if.level_raw   = 1'b1;
    bus_if.pattern_raw = 4'b0101;
    repeat (6) tick();
    check("grp_settle_row5", 8'(bus_if.pattern_db), 8'h0);
    tick();
    check("grp_settle_row6_pat", 8'(bus_if.pattern_db), 8'h5);
    check("grp_settle_row6_lvl", 8'(bus_if.level_db), 8'h1);
    $display("group settled: level_db=%b pattern_db=%b", bus_if.level_db, bus_if.pattern_db);

    // ---- table: press held 20 cycles, then released ----
    snap_row = REL ? 26 : 6;
    for (int i = 0; i < 28; i++) begin
      tbl[i].btn          = (i < 20);
      tbl[i].exp_step     = REL ? (i == 26) : (i == 6);
      tbl[i].exp_btn_db   = (i >= 6) && (i < 26);
      tbl[i].exp_lvl_snap = (i >= snap_row);
      tbl[i].exp_pat_snap = (i >= snap_row) ? 4'b0101 : 4'b0000;
    end
    for (int i = 0; i < 28; i++) begin
      bus_if.btn_raw = tbl[i].btn;
      tick();
      $display("row %0d btn=%b step=%b btn_db=%b lsnap=%b psnap=%b",
               i, tbl[i].btn, bus_if.step, bus_if.btn_db, bus_if.level_snap, bus_if.pattern_snap);
      check($sformatf("tbl%0d.step", i),   8'(bus_if.step),         8'(tbl[i].exp_step));
      check($sformatf("tbl%0d.btn_db", i), 8'(bus_if.btn_db),       8'(tbl[i].exp_btn_db));
      check($sformatf("tbl%0d.lsnap", i),  8'(bus_if.level_snap),   8'(tbl[i].exp_lvl_snap));
      check($sformatf("tbl%0d.psnap", i),  8'(bus_if.pattern_snap), 8'(tbl[i].exp_pat_snap));
    end

    // ---- pattern change without a press ----
    bus_if.pattern_raw = 4'b1000;
    repeat (6) tick();
    check("pat1000_row5", 8'(bus_if.pattern_db), 8'h5);
    tick();
    check("pat1000_row6", 8'(bus_if.pattern_db), 8'h8);
    check("pat1000_psnap_hold", 8'(bus_if.pattern_snap), 8'h5);
    check("pat1000_lsnap_hold", 8'(bus_if.level_snap), 8'h1);
    $display("pattern change: pattern_db=%b pattern_snap=%b", bus_if.pattern_db, bus_if.pattern_snap);

    // ---- glitches of 3 and 4 cycles ----
    for (int len = 3; len <= 4; len++) begin
      seen_step = 1'b0;
      seen_db   = 1'b0;
      for (int i = 0; i < 16; i++) begin
        bus_if.btn_raw = (i < len);
        tick();
        seen_step |= bus_if.step;
        seen_db   |= bus_if.btn_db;
      end
      $display("glitch len=%0d step_seen=%b btn_db_seen=%b", len, seen_step, seen_db);
      check($sformatf("glitch%0d_step", len),   8'(seen_step), 8'h0);
      check($sformatf("glitch%0d_btn_db", len), 8'(seen_db),   8'h0);
    end

    // ---- pattern toggling every 2 cycles ----
    pat_moved = 1'b0;
    for (int i = 0; i < 30; i++) begin
      bus_if.pattern_raw = ((i / 2) % 2 == 1) ? 4'b1001 : 4'b0110;
      tick();
      if (bus_if.pattern_db !== 4'b1000) pat_moved = 1'b1;
    end
    check("toggle_db_steady", 8'(pat_moved), 8'h0);
    bus_if.pattern_raw = 4'b0010;
    repeat (6) tick();
    check("toggle_stop_row5", 8'(bus_if.pattern_db), 8'h8);
    tick();
    check("toggle_stop_row6", 8'(bus_if.pattern_db), 8'h2);
    $display("toggle done: pattern_db=%b", bus_if.pattern_db);

    // ---- reset while in PRESS_WAIT ----
    bus_if.btn_raw = 1'b1;
    repeat (4) tick();
    rst = 1'b0;
    #1;
    check_all_zero("midreset_async");
    bus_if.btn_raw = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    seen_step = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen_step |= bus_if.step;
    end
    check("midreset_no_step", 8'(seen_step), 8'h0);
    check("midreset_reload_lvl", 8'(bus_if.level_db), 8'h1);
    check("midreset_reload_pat", 8'(bus_if.pattern_db), 8'h2);
    $display("mid-press reset done: level_db=%b pattern_db=%b", bus_if.level_db, bus_if.pattern_db);

    // ---- 5-cycle press ----
    steps    = 0;
    step_row = -1;
    for (int i = 0; i < 16; i++) begin
      bus_if.btn_raw = (i < 5);
      tick();
      if (bus_if.step === 1'b1) begin
        steps++;
        step_row = i;
      end
      if (i == 6) check("press5_btn_db_row6", 8'(bus_if.btn_db), 8'h1);
    end
    $display("press5: steps=%0d step_row=%0d", steps, step_row);
    check("press5_step_count", 8'(steps), 8'h1);
    check("press5_step_row", 8'(step_row), REL ? 8'd11 : 8'd6);
    check("press5_btn_db_end", 8'(bus_if.btn_db), 8'h0);
    check("press5_lsnap", 8'(bus_if.level_snap), 8'h1);
    check("press5_psnap", 8'(bus_if.pattern_snap), 8'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
